tile_fetch_arbiter: RTL and testbench

- Sequences the single-port 40x30 tile-index RAM (1200 bytes) between the VGA glyph pipeline and the CPU.
- The display side prefetches the tile code of the next 16x16 screen block ahead of the beam and presents it to BitGen on the block boundary.
- CPU reads and writes are served in the free cycles between display fetches, using a req/ack handshake.
- Sits between VGAControl (hCount/vCount) and BitGen, at the 50 MHz clock.

---
 rtl/tile_fetch_arbiter.sv | 176 +++++++++++++++++
 tb/tb_tile_fetch_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_fetch_arbiter.sv
// Tile-index RAM arbiter: prefetches the next block's tile code for the glyph
// pipeline and serves CPU reads/writes in the gaps between display fetches.
module tile_fetch_arbiter #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int V_TOTAL   = 525,
    parameter int COLS      = 40,
    parameter int ROWS      = 30,
    parameter int FETCH_PIX = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pixel_en,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [10:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic [10:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  tile_code,
    output logic        fetch_miss
);

    typedef enum logic [2:0] {
        IDLE, DISP_RD, DISP_CAP, CPU_RD, CPU_CAP, CPU_WR, CPU_NOP
    } state_t;

    state_t      state, state_nxt;
    logic        disp_pending, pending_nxt;
    logic [10:0] pend_addr, pend_addr_nxt;
    logic        next_valid, next_valid_nxt;
    logic [7:0]  tile_next, tile_next_nxt;
    logic [10:0] addr_nxt;
    logic        we_nxt;
    logic [7:0]  wdata_nxt;
    logic        ack_nxt;
    logic [7:0]  rdata_nxt;
    logic [7:0]  tile_code_nxt;
    logic        miss_nxt;

    logic [5:0]  col;
    logic        slot, boundary;
    logic [10:0] tgt_row, tgt_col, tgt_addr;

    assign col      = hCount[9:4];
    assign slot     = pixel_en && (hCount[3:0] == 4'(FETCH_PIX)) && (hCount < 10'(H_ACTIVE))
                      && ((vCount < 10'(V_ACTIVE)) || (col == 6'(COLS - 1)));
    assign boundary = pixel_en && (hCount[3:0] == 4'hF) && (hCount < 10'(H_ACTIVE));

    // Last column of a line prefetches column 0 of the row the next line draws;
    // the last visible line and the last frame line both wrap to row 0.
    always_comb begin
        if (col < 6'(COLS - 1)) begin
            tgt_col = {5'd0, col} + 11'd1;
            tgt_row = {6'd0, vCount[8:4]};
        end else begin
            tgt_col = '0;
            if ((vCount >= 10'(V_ACTIVE - 1)) || (vCount == 10'(V_TOTAL - 1)))
                tgt_row = '0;
            else
                tgt_row = ({1'b0, vCount} + 11'd1) >> 4;
        end
        tgt_addr = tgt_row * 11'(COLS) + tgt_col;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            disp_pending <= 1'b0;
            pend_addr    <= '0;
            next_valid   <= 1'b0;
            tile_next    <= '0;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_wdata    <= '0;
            cpu_ack      <= 1'b0;
            cpu_rdata    <= '0;
            tile_code    <= '0;
            fetch_miss   <= 1'b0;
        end else begin
            state        <= state_nxt;
            disp_pending <= pending_nxt;
            pend_addr    <= pend_addr_nxt;
            next_valid   <= next_valid_nxt;
            tile_next    <= tile_next_nxt;
            mem_addr     <= addr_nxt;
            mem_we       <= we_nxt;
            mem_wdata    <= wdata_nxt;
            cpu_ack      <= ack_nxt;
            cpu_rdata    <= rdata_nxt;
            tile_code    <= tile_code_nxt;
            fetch_miss   <= miss_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pending_nxt    = disp_pending;
        pend_addr_nxt  = pend_addr;
        next_valid_nxt = next_valid;
        tile_next_nxt  = tile_next;
        addr_nxt       = mem_addr;
        we_nxt         = 1'b0;
        wdata_nxt      = mem_wdata;
        ack_nxt        = 1'b0;
        rdata_nxt      = cpu_rdata;
        tile_code_nxt  = tile_code;
        miss_nxt       = 1'b0;

        if (slot) begin
            pending_nxt   = 1'b1;
            pend_addr_nxt = tgt_addr;
        end

        if (boundary) begin
            if (next_valid) begin
                tile_code_nxt  = tile_next;
                next_valid_nxt = 1'b0;
            end else begin
                miss_nxt = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (disp_pending || slot) begin
                    addr_nxt    = slot ? tgt_addr : pend_addr;
                    pending_nxt = 1'b0;
                    state_nxt   = DISP_RD;
                end else if (cpu_req && !cpu_ack) begin
                    // cpu_ack=1 marks the previous request's completion cycle
                    if (cpu_addr >= 11'(COLS * ROWS)) begin
                        state_nxt = CPU_NOP;
                    end else if (cpu_we) begin
                        addr_nxt  = cpu_addr;
                        wdata_nxt = cpu_wdata;
                        we_nxt    = 1'b1;
                        state_nxt = CPU_WR;
                    end else begin
                        addr_nxt  = cpu_addr;
                        state_nxt = CPU_RD;
                    end
                end
            end
            DISP_RD:  state_nxt = DISP_CAP;
            DISP_CAP: begin
                tile_next_nxt  = mem_rdata;
                next_valid_nxt = 1'b1;
                state_nxt      = IDLE;
            end
            CPU_RD:   state_nxt = CPU_CAP;
            CPU_CAP: begin
                rdata_nxt = mem_rdata;
                ack_nxt   = 1'b1;
                state_nxt = IDLE;
            end
            CPU_WR: begin
                ack_nxt   = 1'b1;
                state_nxt = IDLE;
            end
            CPU_NOP: begin
                rdata_nxt = '0;
                ack_nxt   = 1'b1;
                state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tile_fetch_arbiter.sv
// Directed bench for tile_fetch_arbiter with a synchronous RAM model that is
// reloaded with mem[i] = i mod 256 whenever reset is held.
module tb_tile_fetch_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pixel_en;
    logic [9:0]  hCount, vCount;
    logic        cpu_req, cpu_we;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [10:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  tile_code;
    logic        fetch_miss;

    int checks = 0;
    int failures = 0;
    int miss_cnt = 0, ack_cnt = 0, we_cnt = 0;

    logic [7:0] ram [0:2047];

    tile_fetch_arbiter dut (
        .clk(clk), .reset_n(reset_n), .pixel_en(pixel_en), .hCount(hCount), .vCount(vCount),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .tile_code(tile_code),
        .fetch_miss(fetch_miss)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 2048; i++) ram[i] <= 8'(i);
            mem_rdata <= '0;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    always @(negedge clk) begin
        if (fetch_miss) miss_cnt <= miss_cnt + 1;
        if (cpu_ack)    ack_cnt  <= ack_cnt + 1;
        if (mem_we)     we_cnt   <= we_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pix(input int h, input int v);
        @(negedge clk);
        hCount   = 10'(h);
        vCount   = 10'(v);
        pixel_en = 1'b1;
        @(negedge clk);
        pixel_en = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where cpu_ack is seen.
    task automatic cpu_op(input bit we, input int addr, input int wd,
                          output logic [7:0] rd, output int lat);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = 11'(addr);
        cpu_wdata = 8'(wd);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!cpu_ack && lat < 40);
        chk("cpu_ack_seen", 32'(cpu_ack), 1);
        rd = cpu_rdata;
        cpu_req = 1'b0;
    endtask

    // Tile drawn in column c was fetched by the slot of column c-1.
    task automatic sweep_line(input int v, input bit check_addr);
        int c, p;
        for (int h = 0; h < 640; h++) begin
            pix(h, v);
            c = h >> 4;
            p = h & 15;
            if (check_addr && p == 12)
                chk("fetch_addr", 32'(mem_addr),
                    (c < 39) ? ((v >> 4) * 40 + c + 1) : (((v + 1) >> 4) * 40));
            if (p == 4 && c >= 1)
                chk("tile_code", 32'(tile_code), ((v >> 4) * 40 + c) & 255);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int lat, m0, a0, w0, nwr, maxlat;
        bit done;

        reset_n = 1'b0; pixel_en = 1'b0; hCount = '0; vCount = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        idle(3);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_cpu_ack", 32'(cpu_ack), 0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
        chk("rst_tile_code", 32'(tile_code), 0);
        chk("rst_fetch_miss", 32'(fetch_miss), 0);
        reset_n = 1'b1;

        // reset while a write is in its mem_we cycle
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'd5; cpu_wdata = 8'h33;
        @(negedge clk);
        chk("midwr_we_before", 32'(mem_we), 1);
        reset_n = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        chk("midwr_we", 32'(mem_we), 0);
        chk("midwr_ack", 32'(cpu_ack), 0);
        chk("midwr_tile", 32'(tile_code), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("midwr_no_ack", 32'(cpu_ack), 0);

        // line scan at vCount=37 (tile row 2)
        m0 = miss_cnt;
        sweep_line(37, 1'b1);
        idle(2);
        chk("scan_miss", 32'(miss_cnt - m0), 0);
        chk("scan_hblank_tile", 32'(tile_code), 80);

        // CPU write/read
        cpu_op(1'b1, 0, 'h5A, rd, lat);
        chk("wr0_lat", 32'(lat), 2);
        @(negedge clk);
        w0 = we_cnt;
        cpu_op(1'b1, 1199, 'hA5, rd, lat);
        chk("wr_lat", 32'(lat), 2);
        @(negedge clk);
        chk("wr_ack_pulse", 32'(cpu_ack), 0);
        chk("wr_we_cycles", 32'(we_cnt - w0), 1);
        cpu_op(1'b0, 1199, 0, rd, lat);
        chk("rd_lat", 32'(lat), 3);
        chk("rd_data", 32'(rd), 'hA5);
        @(negedge clk);
        chk("rd_ack_pulse", 32'(cpu_ack), 0);

        // wrap targets: last visible line and last frame line fetch address 0
        pix(632, 479);
        idle(3);
        chk("wrap479_addr", 32'(mem_addr), 0);
        pix(639, 479);
        chk("wrap479_tile", 32'(tile_code), 'h5A);
        chk("wrap479_miss", 32'(fetch_miss), 0);
        cpu_op(1'b0, 7, 0, rd, lat);
        chk("rd7_data", 32'(rd), 7);
        pix(632, 524);
        idle(3);
        chk("wrap524_addr", 32'(mem_addr), 0);
        pix(639, 524);
        chk("wrap524_tile", 32'(tile_code), 'h5A);
        pix(88, 500);
        idle(3);
        chk("vblank_no_access", 32'(mem_addr), 0);

        // slot lands while a CPU read is in flight
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'd10;
        @(negedge clk);
        hCount = 10'd8; vCount = 10'd100; pixel_en = 1'b1;
        @(negedge clk);
        pixel_en = 1'b0;
        chk("coll_ack_early", 32'(cpu_ack), 0);
        @(negedge clk);
        chk("coll_ack", 32'(cpu_ack), 1);
        chk("coll_rdata", 32'(cpu_rdata), 10);
        chk("coll_addr_cpu", 32'(mem_addr), 10);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("coll_disp_addr", 32'(mem_addr), 241);
        chk("coll_ack_drop", 32'(cpu_ack), 0);
        m0 = miss_cnt;
        for (int h = 9; h < 16; h++) pix(h, 100);
        chk("coll_tile", 32'(tile_code), 241);
        idle(1);
        chk("coll_miss", 32'(miss_cnt - m0), 0);

        // out-of-range read
        w0 = we_cnt;
        cpu_op(1'b0, 1500, 0, rd, lat);
        chk("oor_lat", 32'(lat), 2);
        chk("oor_rdata", 32'(rd), 0);
        chk("oor_addr", 32'(mem_addr), 241);
        idle(1);
        chk("oor_no_we", 32'(we_cnt - w0), 0);

        // back-to-back CPU writes across a whole line
        m0 = miss_cnt; a0 = ack_cnt; w0 = we_cnt;
        nwr = 0; maxlat = 0; done = 1'b0;
        fork
            begin
                sweep_line(200, 1'b0);
                done = 1'b1;
            end
            begin
                logic [7:0] rb;
                int lb;
                int k;
                k = 0;
                while (!done) begin
                    cpu_op(1'b1, 600 + (k % 400), k, rb, lb);
                    if (lb > maxlat) maxlat = lb;
                    k++;
                    nwr++;
                end
            end
        join
        idle(2);
        chk("b2b_miss", 32'(miss_cnt - m0), 0);
        chk("b2b_acks", 32'(ack_cnt - a0), 32'(nwr));
        chk("b2b_we", 32'(we_cnt - w0), 32'(nwr));
        chk("b2b_lat_bound", 32'(maxlat <= 6), 1);
        chk("b2b_traffic", 32'(nwr >= 150), 1);
        chk("b2b_tile", 32'(tile_code), 224);
        cpu_op(1'b0, 601, 0, rd, lat);
        chk("b2b_readback", 32'(rd), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
